// File: rtl/mcu_ctrl_fsm.sv
// mcu_ctrl_fsm: multicycle RV32I control unit.
// Sequences FETCH/EXEC/WB/INTER/TRAP for every instruction and performs the
// memory handshake with a saturating wait counter and optional timeout trap.
// It also tracks sticky interrupt pending bits and resolves the winning channel
// by fixed priority, where channel 0 has the highest priority.
// Interrupts are only taken at instruction completion. A trap never checks for
// interrupts on its way back to FETCH.
// Control outputs are decodes of state and inputs, gated by RST_N so that an
// asserted reset silences them immediately, including mid-transaction.

module mcu_ctrl_fsm #(
  parameter int NUM_IRQ     = 4,
  parameter int MEM_TIMEOUT = 15,
  localparam int IDW        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [6:0]         OPCODE,
  input  logic [2:0]         FUNC3,
  input  logic               MEM_READY,
  input  logic [NUM_IRQ-1:0] IRQ,
  input  logic [NUM_IRQ-1:0] IRQ_MASK,
  input  logic               IRQ_EN,
  output logic               PC_WRITE,
  output logic               REG_WRITE,
  output logic               CSR_WRITE,
  output logic               MEM_READ1,
  output logic               MEM_READ2,
  output logic               MEM_WRITE,
  output logic               INT_TAKEN,
  output logic [IDW-1:0]     INT_ID,
  output logic               TRAP,
  output logic [1:0]         TRAP_CAUSE,
  output logic [NUM_IRQ-1:0] IRQ_PENDING
);

  // Wait counter wide enough to reach MEM_TIMEOUT; it saturates at all-ones.
  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic          TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_LIMIT  = CW'(MEM_TIMEOUT);

  // RV32I major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd0;
  localparam logic [1:0] CAUSE_FETCH   = 2'd1;
  localparam logic [1:0] CAUSE_DATA    = 2'd2;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC  = 3'd1,
    ST_WB    = 3'd2,
    ST_INTER = 3'd3,
    ST_TRAP  = 3'd4
  } state_t;

  state_t             state_r;
  logic [CW-1:0]      wait_cnt_r;
  logic [NUM_IRQ-1:0] pend_r;
  logic [IDW-1:0]     int_id_r;
  logic [1:0]         trap_cause_r;

  logic [NUM_IRQ-1:0] masked_s;
  logic [NUM_IRQ-1:0] clr_s;
  logic [IDW-1:0]     winner_s;
  logic               irq_go_s;
  logic               timeout_s;

  logic pc_write_s, reg_write_s, csr_write_s;
  logic mem_read1_s, mem_read2_s, mem_write_s;
  logic int_taken_s, trap_s;

  // Fixed priority: lowest-index requesting channel wins.
  function automatic logic [IDW-1:0] pick_winner(input logic [NUM_IRQ-1:0] req);
    logic [IDW-1:0] id;
    id = {IDW{1'b0}};
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        id = IDW'(i);
      end else begin
        id = id;
      end
    end
    return id;
  endfunction

  // One-hot expansion of a channel index (used to retire the serviced channel).
  function automatic logic [NUM_IRQ-1:0] id_onehot(input logic [IDW-1:0] id);
    logic [NUM_IRQ-1:0] vec;
    vec = {NUM_IRQ{1'b0}};
    for (int i = 0; i < NUM_IRQ; i++) begin
      vec[i] = (id == IDW'(i));
    end
    return vec;
  endfunction

  assign masked_s  = pend_r & IRQ_MASK;
  assign irq_go_s  = IRQ_EN & (|masked_s);
  assign winner_s  = pick_winner(masked_s);
  assign timeout_s = TIMEOUT_EN && (wait_cnt_r == CNT_LIMIT) && !MEM_READY;
  assign clr_s     = (state_r == ST_INTER) ? id_onehot(int_id_r) : {NUM_IRQ{1'b0}};

  // Sequencer: state, wait counter, sticky pending bits, latched winner and trap cause.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r      <= ST_FETCH;
      wait_cnt_r   <= CNT_ZERO;
      pend_r       <= {NUM_IRQ{1'b0}};
      int_id_r     <= {IDW{1'b0}};
      trap_cause_r <= 2'd0;
    end else begin
      // A new request in the same cycle as the clear keeps the channel pending.
      pend_r <= (pend_r & ~clr_s) | IRQ;
      if (!MEM_READY && (wait_cnt_r != CNT_MAX)) begin
        wait_cnt_r <= wait_cnt_r + CNT_ONE;
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
      case (state_r)
        ST_FETCH: begin
          if (MEM_READY) begin
            state_r    <= ST_EXEC;
            wait_cnt_r <= CNT_ZERO;
          end else if (timeout_s) begin
            state_r      <= ST_TRAP;
            trap_cause_r <= CAUSE_FETCH;
            wait_cnt_r   <= CNT_ZERO;
          end else begin
            state_r <= ST_FETCH;
          end
        end
        ST_EXEC: begin
          case (OPCODE)
            OPC_LOAD: begin
              if (MEM_READY) begin
                state_r    <= ST_WB;
                wait_cnt_r <= CNT_ZERO;
              end else if (timeout_s) begin
                state_r      <= ST_TRAP;
                trap_cause_r <= CAUSE_DATA;
                wait_cnt_r   <= CNT_ZERO;
              end else begin
                state_r <= ST_EXEC;
              end
            end
            OPC_STORE: begin
              if (MEM_READY) begin
                state_r    <= irq_go_s ? ST_INTER : ST_FETCH;
                int_id_r   <= irq_go_s ? winner_s : int_id_r;
                wait_cnt_r <= CNT_ZERO;
              end else if (timeout_s) begin
                state_r      <= ST_TRAP;
                trap_cause_r <= CAUSE_DATA;
                wait_cnt_r   <= CNT_ZERO;
              end else begin
                state_r <= ST_EXEC;
              end
            end
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_OP, OPC_OP_IMM, OPC_BRANCH, OPC_SYSTEM: begin
              state_r    <= irq_go_s ? ST_INTER : ST_FETCH;
              int_id_r   <= irq_go_s ? winner_s : int_id_r;
              wait_cnt_r <= CNT_ZERO;
            end
            default: begin
              state_r      <= ST_TRAP;
              trap_cause_r <= CAUSE_ILLEGAL;
              wait_cnt_r   <= CNT_ZERO;
            end
          endcase
        end
        ST_WB: begin
          state_r    <= irq_go_s ? ST_INTER : ST_FETCH;
          int_id_r   <= irq_go_s ? winner_s : int_id_r;
          wait_cnt_r <= CNT_ZERO;
        end
        ST_INTER: begin
          state_r    <= ST_FETCH;
          wait_cnt_r <= CNT_ZERO;
        end
        ST_TRAP: begin
          state_r    <= ST_FETCH;
          wait_cnt_r <= CNT_ZERO;
        end
        default: begin
          state_r    <= ST_FETCH;
          wait_cnt_r <= CNT_ZERO;
        end
      endcase
    end
  end

  // Control decode from the current state, opcode and memory handshake.
  always_comb begin
    pc_write_s  = 1'b0;
    reg_write_s = 1'b0;
    csr_write_s = 1'b0;
    mem_read1_s = 1'b0;
    mem_read2_s = 1'b0;
    mem_write_s = 1'b0;
    int_taken_s = 1'b0;
    trap_s      = 1'b0;
    case (state_r)
      ST_FETCH: begin
        mem_read1_s = 1'b1;
      end
      ST_EXEC: begin
        case (OPCODE)
          OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP, OPC_OP_IMM: begin
            pc_write_s  = 1'b1;
            reg_write_s = 1'b1;
          end
          OPC_BRANCH: begin
            pc_write_s = 1'b1;
          end
          OPC_SYSTEM: begin
            pc_write_s = 1'b1;
            if (FUNC3 == 3'b001) begin
              reg_write_s = 1'b1;
              csr_write_s = 1'b1;
            end else begin
              reg_write_s = 1'b0;
              csr_write_s = 1'b0;
            end
          end
          OPC_LOAD: begin
            mem_read2_s = 1'b1;
          end
          OPC_STORE: begin
            mem_write_s = 1'b1;
            if (MEM_READY) begin
              pc_write_s = 1'b1;
            end else begin
              pc_write_s = 1'b0;
            end
          end
          default: begin
            pc_write_s = 1'b0;
          end
        endcase
      end
      ST_WB: begin
        pc_write_s  = 1'b1;
        reg_write_s = 1'b1;
      end
      ST_INTER: begin
        pc_write_s  = 1'b1;
        int_taken_s = 1'b1;
      end
      ST_TRAP: begin
        pc_write_s = 1'b1;
        trap_s     = 1'b1;
      end
      default: begin
        pc_write_s = 1'b0;
      end
    endcase
  end

  assign PC_WRITE    = pc_write_s  & RST_N;
  assign REG_WRITE   = reg_write_s & RST_N;
  assign CSR_WRITE   = csr_write_s & RST_N;
  assign MEM_READ1   = mem_read1_s & RST_N;
  assign MEM_READ2   = mem_read2_s & RST_N;
  assign MEM_WRITE   = mem_write_s & RST_N;
  assign INT_TAKEN   = int_taken_s & RST_N;
  assign TRAP        = trap_s      & RST_N;
  assign INT_ID      = int_id_r;
  assign TRAP_CAUSE  = trap_cause_r;
  assign IRQ_PENDING = pend_r;

endmodule
